uart_tx_ctrl: RTL

//  Upstream controller for the UART Tx PISO shift register. Buffers bytes from a

---
 rtl/uart_tx_ctrl.sv | 93 +++++++++
 1 files changed

// File: rtl/uart_tx_ctrl.sv
// Feeds a UART Tx PISO shift register from a small byte FIFO, adding the bit8
// (parity or extra stop) and sequencing valid / tx_busy so frames are 11 clks.
module uart_tx_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [7:0]                  in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic                        sr_valid,
  output logic                        sr_tx_busy,
  output logic [8:0]                  sr_data,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        frame_done
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t          state, next_state;
  logic [3:0]      bit_cnt;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count;
  logic            full, empty, push, pop;
  logic [7:0]      head;
  logic            bit8;

  assign full       = (count == CW'(FIFO_DEPTH));
  assign empty      = (count == '0);
  assign in_ready   = !full;
  assign push       = in_valid && !full;
  assign pop        = sr_valid;
  assign fifo_count = count;
  assign head       = mem[rd_ptr];

  // bit8 is parity when enabled, otherwise a constant 1 that acts as a second stop bit
  assign bit8    = (PARITY_EN != 0) ? ((^head) ^ logic'(PARITY_ODD != 0)) : 1'b1;
  assign sr_data = empty ? 9'h1FF : {bit8, head};

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      bit_cnt <= '0;
    end else begin
      state   <= next_state;
      bit_cnt <= (state == SEND && next_state == SEND) ? bit_cnt + 4'd1 : 4'd0;
    end
  end

  always_comb begin
    next_state = state;
    sr_valid   = 1'b0;
    sr_tx_busy = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        sr_valid = !empty;
        if (!empty) next_state = SEND;
      end
      SEND: begin
        sr_tx_busy = 1'b1;
        // bit_cnt 9 is the stop-bit cycle; the following edge may load the next frame
        if (bit_cnt == 4'd9) begin
          frame_done = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end
endmodule
